// File: rtl/lmsm_sequencer.sv
// LM/SM micro-op sequencer for the ID stage. It expands one load/store-multiple
// into a run of single-register micro-ops, one per set bit of the register mask.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start_valid/is_lm    LM/SM instruction present in ID, load (1) or store (0)
//   start_base/mask      RA base register, imm8 mask (bit 7 = R0 .. bit 0 = R7)
//   stall, flush         ID/EX not loading this cycle / redirect abort
//   fetch_stall, id_kill hold PC and IF/ID / bubble the ID instruction
//   busy                 sequencer is in RUN
//   uop_*                micro-op presented to ID/EX
//   done                 pulse after the last micro-op or a zero-mask accept
module lmsm_sequencer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_STEP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  input  logic              start_is_lm,
  input  logic [2:0]        start_base,
  input  logic [7:0]        start_mask,
  input  logic              stall,
  input  logic              flush,
  output logic              fetch_stall,
  output logic              id_kill,
  output logic              busy,
  output logic              uop_valid,
  output logic              uop_is_load,
  output logic [2:0]        uop_reg,
  output logic [2:0]        uop_base,
  output logic [DATA_W-1:0] uop_offset,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic [7:0]        mask_q;
  logic [DATA_W-1:0] offset_q;
  logic [2:0]        base_q;
  logic              lm_q;
  logic              done_q;

  logic       run;
  logic       accept;
  logic       consume;
  logic       last_bit;
  logic [2:0] sel_reg;
  logic [7:0] sel_bit;
  logic [7:0] mask_left;

  assign run = (state_q == RUN);

  // rst_n gating keeps every output at 0 while reset is held.
  assign accept = rst_n & !run & start_valid
                & !stall & !flush;

  assign consume = run & !stall & !flush;

  // Highest set bit wins: mask bit 7 is R0, so this walks R0 first.
  always_comb begin
    sel_reg = '0;
    for (int i = 0; i < 8; i++) begin
      if (mask_q[i]) sel_reg = 3'(7 - i);
    end
  end

  assign sel_bit   = 8'h80 >> sel_reg;
  assign mask_left = mask_q & ~sel_bit;
  assign last_bit  = (mask_left == 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && start_mask != 8'h00)
              state_d = RUN;
      RUN:  if (consume && last_bit)
              state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q   <= '0;
      offset_q <= '0;
      base_q   <= '0;
      lm_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (accept & ~|start_mask)
              | (consume & last_bit);
      if (flush) begin
        mask_q <= '0;
      end else if (accept) begin
        mask_q   <= start_mask;
        base_q   <= start_base;
        lm_q     <= start_is_lm;
        offset_q <= '0;
      end else if (consume) begin
        mask_q   <= mask_left;
        offset_q <= offset_q + DATA_W'(ADDR_STEP);
      end
    end
  end

  always_comb begin
    fetch_stall = 1'b0;
    id_kill     = 1'b0;
    busy        = run;
    uop_valid   = 1'b0;
    uop_is_load = 1'b0;
    uop_reg     = '0;
    uop_base    = '0;
    uop_offset  = '0;
    done        = done_q;
    if (accept) begin
      id_kill     = 1'b1;
      fetch_stall = |start_mask;
    end
    if (run) begin
      uop_valid   = !flush;
      uop_is_load = lm_q;
      uop_reg     = sel_reg;
      uop_base    = base_q;
      uop_offset  = offset_q;
      // Release fetch as the last micro-op is consumed: no bubble after.
      fetch_stall = !(last_bit && !stall) && !flush;
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed testbench for lmsm_sequencer.
// Inputs change 1ns after posedge; outputs are compared at negedge.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid;
  logic        start_is_lm;
  logic [2:0]  start_base;
  logic [7:0]  start_mask;
  logic        stall;
  logic        flush;
  logic        fetch_stall;
  logic        id_kill;
  logic        busy;
  logic        uop_valid;
  logic        uop_is_load;
  logic [2:0]  uop_reg;
  logic [2:0]  uop_base;
  logic [15:0] uop_offset;
  logic        done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lmsm_sequencer #(.DATA_W(16), .ADDR_STEP(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_valid(start_valid),
    .start_is_lm(start_is_lm),
    .start_base(start_base),
    .start_mask(start_mask),
    .stall(stall),
    .flush(flush),
    .fetch_stall(fetch_stall),
    .id_kill(id_kill),
    .busy(busy),
    .uop_valid(uop_valid),
    .uop_is_load(uop_is_load),
    .uop_reg(uop_reg),
    .uop_base(uop_base),
    .uop_offset(uop_offset),
    .done(done)
  );

  logic [27:0] obs;
  assign obs = {fetch_stall, id_kill, busy,
                uop_valid, uop_is_load, uop_reg,
                uop_base, uop_offset, done};

  function automatic logic [27:0] x(
    input bit fs, input bit ik, input bit bz,
    input bit uv, input bit ld,
    input logic [2:0] rg, input logic [2:0] bs,
    input logic [15:0] off, input bit dn);
    return {fs, ik, bz, uv, ld, rg, bs, off, dn};
  endfunction

  function automatic logic [14:0] st(
    input bit sv, input bit lm,
    input logic [2:0] b, input logic [7:0] m,
    input bit sl, input bit fl);
    return {sv, lm, b, m, sl, fl};
  endfunction

  localparam logic [27:0] Z = 28'h0;
  localparam logic [14:0] S0 = 15'h0;

  task automatic test_reset();
    rst_n = 1'b0;
    {start_valid, start_is_lm, start_base,
     start_mask, stall, flush} = st(1, 1, 3, 8'hFF, 0, 0);
    #3;
    checks++;
    if (obs !== Z) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", obs, Z);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== Z) begin
      failures++;
      $display("FAIL reset_held got=%h exp=%h", obs, Z);
    end
    {start_valid, start_is_lm, start_base,
     start_mask, stall, flush} = S0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_lm();
    logic [14:0] s [6];
    logic [27:0] e [6];
    s = '{st(1, 1, 3, 8'hA1, 0, 0), S0, S0, S0, S0, S0};
    e = '{x(1, 1, 0, 0, 0, 0, 0, 0, 0),
          x(1, 0, 1, 1, 1, 0, 3, 0, 0),
          x(1, 0, 1, 1, 1, 2, 3, 2, 0),
          x(0, 0, 1, 1, 1, 7, 3, 4, 0),
          x(0, 0, 0, 0, 0, 0, 0, 0, 1),
          Z};
    for (int i = 0; i < 6; i++) begin
      {start_valid, start_is_lm, start_base,
       start_mask, stall, flush} = s[i];
      @(negedge clk);
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL basic_lm cyc%0d got=%h exp=%h",
                 i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sm_stall();
    logic [14:0] s [12];
    logic [27:0] e [12];
    logic [14:0] h;
    h = st(0, 0, 0, 0, 1, 0);
    s = '{st(1, 0, 5, 8'hFF, 0, 0), S0, S0, h, h,
          S0, S0, S0, S0, S0, S0, S0};
    e = '{x(1, 1, 0, 0, 0, 0, 0, 0, 0),
          x(1, 0, 1, 1, 0, 0, 5, 0, 0),
          x(1, 0, 1, 1, 0, 1, 5, 2, 0),
          x(1, 0, 1, 1, 0, 2, 5, 4, 0),
          x(1, 0, 1, 1, 0, 2, 5, 4, 0),
          x(1, 0, 1, 1, 0, 2, 5, 4, 0),
          x(1, 0, 1, 1, 0, 3, 5, 6, 0),
          x(1, 0, 1, 1, 0, 4, 5, 8, 0),
          x(1, 0, 1, 1, 0, 5, 5, 10, 0),
          x(1, 0, 1, 1, 0, 6, 5, 12, 0),
          x(0, 0, 1, 1, 0, 7, 5, 14, 0),
          x(0, 0, 0, 0, 0, 0, 0, 0, 1)};
    for (int i = 0; i < 12; i++) begin
      {start_valid, start_is_lm, start_base,
       start_mask, stall, flush} = s[i];
      @(negedge clk);
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL sm_stall cyc%0d got=%h exp=%h",
                 i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_mask();
    logic [14:0] s [5];
    logic [27:0] e [5];
    s = '{st(1, 0, 0, 8'h00, 1, 0),
          st(1, 0, 0, 8'h00, 0, 1),
          st(1, 1, 0, 8'h00, 0, 0),
          S0, S0};
    e = '{Z, Z,
          x(0, 1, 0, 0, 0, 0, 0, 0, 0),
          x(0, 0, 0, 0, 0, 0, 0, 0, 1),
          Z};
    for (int i = 0; i < 5; i++) begin
      {start_valid, start_is_lm, start_base,
       start_mask, stall, flush} = s[i];
      @(negedge clk);
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL zero_mask cyc%0d got=%h exp=%h",
                 i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    logic [14:0] s [5];
    logic [27:0] e [5];
    s = '{st(1, 1, 1, 8'hF0, 0, 0), S0,
          st(0, 0, 0, 0, 1, 1), S0, S0};
    e = '{x(1, 1, 0, 0, 0, 0, 0, 0, 0),
          x(1, 0, 1, 1, 1, 0, 1, 0, 0),
          x(0, 0, 1, 0, 1, 1, 1, 2, 0),
          Z, Z};
    for (int i = 0; i < 5; i++) begin
      {start_valid, start_is_lm, start_base,
       start_mask, stall, flush} = s[i];
      @(negedge clk);
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL flush cyc%0d got=%h exp=%h",
                 i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_run();
    logic [14:0] s [3];
    logic [27:0] e [3];
    logic [27:0] r [3];
    s = '{st(1, 1, 0, 8'hF0, 0, 0), S0, S0};
    e = '{x(1, 1, 0, 0, 0, 0, 0, 0, 0),
          x(1, 0, 1, 1, 1, 0, 0, 0, 0),
          x(1, 0, 1, 1, 1, 1, 0, 2, 0)};
    for (int i = 0; i < 3; i++) begin
      {start_valid, start_is_lm, start_base,
       start_mask, stall, flush} = s[i];
      @(negedge clk);
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL rst_run cyc%0d got=%h exp=%h",
                 i, obs, e[i]);
      end
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== Z) begin
      failures++;
      $display("FAIL rst_run_drop got=%h exp=%h", obs, Z);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    r = '{x(1, 1, 0, 0, 0, 0, 0, 0, 0),
          x(0, 0, 1, 1, 1, 7, 2, 0, 0),
          x(0, 0, 0, 0, 0, 0, 0, 0, 1)};
    s = '{st(1, 1, 2, 8'h01, 0, 0), S0, S0};
    for (int i = 0; i < 3; i++) begin
      {start_valid, start_is_lm, start_base,
       start_mask, stall, flush} = s[i];
      @(negedge clk);
      checks++;
      if (obs !== r[i]) begin
        failures++;
        $display("FAIL rst_after cyc%0d got=%h exp=%h",
                 i, obs, r[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] s [6];
    logic [27:0] e [6];
    s = '{st(1, 1, 4, 8'h80, 0, 0),
          st(1, 0, 6, 8'h40, 0, 0),
          st(1, 0, 6, 8'h40, 0, 0),
          S0, S0, S0};
    e = '{x(1, 1, 0, 0, 0, 0, 0, 0, 0),
          x(0, 0, 1, 1, 1, 0, 4, 0, 0),
          x(1, 1, 0, 0, 0, 0, 0, 0, 1),
          x(0, 0, 1, 1, 0, 1, 6, 0, 0),
          x(0, 0, 0, 0, 0, 0, 0, 0, 1),
          Z};
    for (int i = 0; i < 6; i++) begin
      {start_valid, start_is_lm, start_base,
       start_mask, stall, flush} = s[i];
      @(negedge clk);
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL b2b cyc%0d got=%h exp=%h",
                 i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic_lm();
    test_sm_stall();
    test_zero_mask();
    test_flush();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/lmsm_sequencer.md
Name: lmsm_sequencer

Overview:
- Micro-op sequencer for the IITB-RISC-23 load-multiple/store-multiple instructions (LM/SM), placed in the ID stage, ahead of the ID/EX pipeline register.
- When an LM or SM is accepted, the block stalls fetch/decode and kills the original instruction.
- It then emits one single-register load or store micro-op per cycle, one for each set bit of the 8-bit register mask.
- It honours the pipeline-wide stall and flush controls that drive the downstream pipeline registers.

Parameters:
- DATA_W, 16, width of the address offset.
- ADDR_STEP, 2, byte-address increment between consecutive transferred registers.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  ID stage holds a valid LM/SM instruction.
- start_is_lm  input  1  1 = LM (load), 0 = SM (store).
- start_base  input  3  RA field, the base-address register.
- start_mask  input  8  imm8 register mask. Bit 7 = R0 … bit 0 = R7.
- stall  input  1  downstream pipeline stall. ID/EX is not loading this cycle.
- flush  input  1  branch/jump redirect. Abort the instruction.
- fetch_stall  output  1  hold PC and IF/ID.
- id_kill  output  1  replace the current ID instruction with a bubble.
- busy  output  1  sequencer is in RUN.
- uop_valid  output  1  micro-op presented to ID/EX.
- uop_is_load  output  1  1 = load into uop_reg, 0 = store from uop_reg.
- uop_reg  output  3  register being transferred.
- uop_base  output  3  base register.
- uop_offset  output  DATA_W  byte offset added to the base register.
- done  output  1  one-cycle pulse after the last micro-op is consumed, or after a zero-mask accept.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; mask_q=0, offset_q=0, base_q=0, lm_q=0, done=0.
  - All combinational outputs evaluate to 0.
  - Reset mid-RUN abandons the remaining micro-ops.
- States: IDLE, RUN.
- accept = IDLE & start_valid & !stall & !flush.
- IDLE transitions:
  - accept with start_mask != 0: latch mask_q=start_mask, base_q, lm_q, offset_q=0; go to RUN next cycle. id_kill=1 and fetch_stall=1 in the accept cycle.
  - accept with start_mask == 0: stay in IDLE. id_kill=1, no stall. done=1 the next cycle; the instruction retires as a NOP.
  - start_valid while stall or flush is high: not accepted, no state change.
- RUN outputs:
  - uop_valid = !flush.
  - uop_reg = index of the highest set bit of mask_q, mapped so that bit 7 → R0 and bit 0 → R7.
  - uop_offset = offset_q; uop_is_load = lm_q; uop_base = base_q; busy = 1.
- Micro-op consumption (RUN & !stall & !flush):
  - The presented micro-op is consumed.
  - The selected bit of mask_q is cleared; offset_q += ADDR_STEP (modulo 2^DATA_W).
  - If it was the last set bit: go to IDLE and pulse done=1 next cycle.
- RUN & stall: hold all state; the same micro-op is re-presented.
- fetch_stall in RUN = !(last_bit & !stall) & !flush. It drops in the cycle the last micro-op is consumed, so the next instruction enters ID in the following cycle with no bubble.
- flush (highest priority, either state):
  - Next state is IDLE; mask_q cleared; no done pulse.
  - fetch_stall, id_kill and uop_valid are forced to 0 in the flush cycle.
- Simultaneous flush & stall: flush wins.
- Throughput: N set bits take exactly N unstalled RUN cycles, plus the accept cycle.
- Micro-op ordering is strictly R0 → R7 among the selected registers. Offsets are 0, 2, 4, … in consumption order, not register index.
- Only one LM/SM is in flight at a time. start_valid in RUN is ignored, because IF/ID is held.

Test Plan:
1. Basic LM:
   - Stimulus: start_valid=1, is_lm=1, base=R3, mask=8'b1010_0001; no stall.
   - Required: uops (R0, off 0), (R2, off 2), (R7, off 4), all is_load=1, on cycles T+1..T+3.
   - fetch_stall high T..T+2, low T+3; done pulse at T+4.
2. SM with stall:
   - Stimulus: mask=8'hFF, is_lm=0; stall=1 for 2 cycles during the third micro-op.
   - Required: R2/off 4 is held for 3 cycles, then R3..R7 follow with offsets 6..14.
   - Total of 8 consumed micro-ops; busy stays high throughout.
3. Zero mask:
   - Stimulus: start_valid=1, mask=0.
   - Required: id_kill=1 for one cycle, fetch_stall=0, uop_valid never asserts, done=1 in the next cycle.
4. Flush mid-sequence:
   - Stimulus: mask=8'b1111_0000; flush=1 in the cycle R1 is presented.
   - Required: uop_valid=0 that cycle; state IDLE next cycle; R2/R3 never issued; no done pulse.
5. Reset mid-RUN:
   - Stimulus: assert rst_n=0 asynchronously while the R1 micro-op is presented.
   - Required: busy, uop_valid and fetch_stall drop immediately.
   - After release, a new LM with mask=8'h01 issues R7 at offset 0.
6. Back-to-back:
   - Stimulus: LM with mask=8'h80, followed immediately by an SM with mask=8'h40 in ID.
   - Required: R0 load at T+1, fetch_stall low at T+1, SM accepted at T+2, R1 store issued at T+3 with offset 0.
